// File: rtl/imu_msg_reader393.sv
// Purpose: drains one message from a logger source and emits it as a fixed 32-word record.
// Latency: first record word valid 1 cycle after rdy is sampled in IDLE (ts low, output free).
// Backpressure: dout_ready low freezes dout/dout_valid/widx/state and suppresses rd_stb.
//
// Ports:
//   xclk, rst_n        clock, asynchronous active-low reset
//   en                 synchronous enable; low drops any record in progress
//   ts, rdy            source timestamp request (pulse) and message-ready (level)
//   rd_stb, rdata      source read strobe and combinational read data
//   ts_sec, ts_usec    free-running local time
//   dout, dout_valid,
//   dout_ready         registered record stream towards the logger buffer
//   busy, ovr          record in progress; sticky abort/timestamp-overrun flag
module imu_msg_reader393 #(
    parameter logic [3:0] CHANNEL       = 4'h0,
    parameter int         PAYLOAD_WORDS = 28
) (
    input  logic        xclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        ts,
    input  logic        rdy,
    output logic        rd_stb,
    input  logic [15:0] rdata,
    input  logic [31:0] ts_sec,
    input  logic [19:0] ts_usec,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        busy,
    output logic        ovr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        PAD     = 2'd3
    } state_t;

    // widx of the last payload word; record always ends at widx 31
    localparam logic [4:0] LAST_PAYLOAD = 5'(PAYLOAD_WORDS + 3);

    state_t      state, state_nxt;
    logic [4:0]  widx, widx_nxt;       // index of the next word to be loaded
    logic [15:0] dout_nxt;
    logic        dout_valid_nxt;
    logic        ld;                   // output register may take a new word
    logic        load;                 // a word is written into dout this cycle
    logic        start;                // IDLE -> HDR, header snapshot taken
    logic        abort;                // message cut short inside PAYLOAD
    logic        ovr_set;

    logic [51:0] ts_reg;               // {sec, usec} from the latest ts request
    logic        ts_valid;
    logic [51:0] rec_ts;               // timestamp frozen for the current record
    logic        rec_nots;

    // Header word for index 0..3; tsv is {sec[31:0], usec[19:0]}
    function automatic logic [15:0] hdr_word(input logic [1:0] idx,
                                             input logic [51:0] tsv,
                                             input logic nots);
        logic [15:0] w;
        case (idx)
            2'd0:    w = tsv[15:0];
            2'd1:    w = {CHANNEL, nots, 7'h0, tsv[19:16]};
            2'd2:    w = tsv[35:20];
            default: w = tsv[51:36];
        endcase
        return w;
    endfunction

    always_comb begin
        ld        = !dout_valid || dout_ready;
        state_nxt = state;
        widx_nxt  = widx;
        dout_nxt  = dout;
        load      = 1'b0;
        rd_stb    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;

        case (state)
            IDLE: begin
                // A ts in the same cycle wins: the new timestamp is captured
                // first and the record starts one cycle later.
                if (rdy && !ts && ld) begin
                    start     = 1'b1;
                    load      = 1'b1;
                    dout_nxt  = hdr_word(2'd0, ts_reg, !ts_valid);
                    widx_nxt  = 5'd1;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                if (ld) begin
                    load     = 1'b1;
                    dout_nxt = hdr_word(widx[1:0], rec_ts, rec_nots);
                    widx_nxt = widx + 5'd1;
                    if (widx == 5'd3) begin
                        state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                // Abort is taken even while stalled; the remaining words of
                // the record are then zeros loaded from PAD.
                if (ts || !rdy) begin
                    abort     = 1'b1;
                    state_nxt = PAD;
                    if (ld) begin
                        load     = 1'b1;
                        dout_nxt = 16'h0000;
                        widx_nxt = widx + 5'd1;
                        if (widx == 5'd31) begin
                            state_nxt = IDLE;
                        end
                    end
                end else if (ld) begin
                    load     = 1'b1;
                    rd_stb   = 1'b1;
                    dout_nxt = rdata;
                    widx_nxt = widx + 5'd1;
                    if (widx == LAST_PAYLOAD) begin
                        state_nxt = (widx == 5'd31) ? IDLE : PAD;
                    end
                end
            end
            PAD: begin
                if (ld) begin
                    load     = 1'b1;
                    dout_nxt = 16'h0000;
                    widx_nxt = widx + 5'd1;
                    if (widx == 5'd31) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!en) begin
            state_nxt = IDLE;
            widx_nxt  = 5'd0;
            dout_nxt  = dout;
            load      = 1'b0;
            rd_stb    = 1'b0;
            start     = 1'b0;
            abort     = 1'b0;
        end

        if (!en) begin
            dout_valid_nxt = 1'b0;
        end else if (load) begin
            dout_valid_nxt = 1'b1;
        end else if (ld) begin
            dout_valid_nxt = 1'b0;
        end else begin
            dout_valid_nxt = dout_valid;
        end

        // start requires !ts, so a capture never coincides with consumption
        ovr_set = en && (abort || (ts && ts_valid));
    end

    always_ff @(posedge xclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            widx       <= 5'd0;
            dout       <= 16'h0000;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            widx       <= widx_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
        end
    end

    always_ff @(posedge xclk or negedge rst_n) begin
        if (!rst_n) begin
            ts_reg   <= 52'd0;
            ts_valid <= 1'b0;
            rec_ts   <= 52'd0;
            rec_nots <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            if (en && ts) begin
                ts_reg   <= {ts_sec, ts_usec};
                ts_valid <= 1'b1;
            end else if (!en || start) begin
                ts_valid <= 1'b0;
            end
            if (start) begin
                rec_ts   <= ts_reg;
                rec_nots <= !ts_valid;
            end
            if (ovr_set) begin
                ovr <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/imu_msg_reader393.md
# imu_msg_reader393

Consumer side of the logger message-source handshake: watches a source's timestamp request (`ts`) and data-ready (`rdy`) lines and latches the local timestamp on `ts`. Once `rdy` is high it drains the source's 28-word (16-bit) message through `rd_stb`/`rdata`. It emits one 32-word record (4 header words + 28 payload words) on a registered valid/ready stream feeding the logger buffer. It runs in the `xclk` domain, the same domain as the source's read port.

## Interface
- `CHANNEL`, 4'h0: source channel number written into header word 1.
- `PAYLOAD_WORDS`, 28: payload words read per message; must be ≤ 28.
- `xclk`  in  1  clock, the logger/source read clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  synchronous enable; low forces IDLE, clears `ts_valid`, deasserts `dout_valid`/`rd_stb`; `ovr` is kept.
- `ts`  in  1  one-cycle timestamp request from source.
- `rdy`  in  1  source message ready (level).
- `rd_stb`  out  1  read strobe to source; advances source read address.
- `rdata`  in  16  source data for the current address; combinational from the source address.
- `ts_sec`  in  32  free-running seconds.
- `ts_usec`  in  20  free-running microseconds.
- `dout`  out  16  record word.
- `dout_valid`  out  1  `dout` holds a word.
- `dout_ready`  in  1  downstream accepts a word when `dout_valid && dout_ready`.
- `busy`  out  1  a record is in progress (state ≠ IDLE).
- `ovr`  out  1  sticky error: message aborted, or `ts` arrived while a captured timestamp was still unused. Cleared only by `rst_n`.

## Operation
- Timestamp capture: `ts` high → `{ts_sec, ts_usec}` → `ts_reg` and `ts_valid` ← 1 at the next edge. If `ts_valid` is already 1 and unused, overwrite it and set `ovr`.
- States: IDLE, HDR, PAYLOAD, PAD. 5-bit word counter `widx` runs 0..31.
- IDLE → HDR when `rdy && !ts`. On this transition:
  - snapshot `ts_reg` into the record;
  - record flag `nots` = `!ts_valid`;
  - clear `ts_valid`.
- HDR emits 4 words, with `widx` 0..3:
  - w0 = usec[15:0]
  - w1 = {CHANNEL, nots, 7'h0, usec[19:16]}
  - w2 = sec[15:0]
  - w3 = sec[31:16]
- HDR → PAYLOAD after w3 is loaded.
- PAYLOAD: each load cycle does two things in the same cycle:
  - `dout` ← `rdata`;
  - `rd_stb` pulses for one cycle.
- PAYLOAD → IDLE after `PAYLOAD_WORDS` strobes. No strobes are issued beyond 28.
- Abort: while in PAYLOAD, if `ts` is high, or `rdy` is low before all words are read, go to PAD and set `ovr`. No further `rd_stb` is issued.
  - The `ts` is captured normally and belongs to the next message.
  - The word loaded in the abort cycle is 16'h0000 and is not strobed.
- PAD: emits 16'h0000 until the record totals 32 words, then → IDLE.
- Records are always exactly 32 words; downstream never sees a short record.
- `ts` and `rdy` both high in IDLE: capture has priority; the transition to HDR waits one cycle, so the new timestamp is used.

## Timing
- Load condition: `ld = !dout_valid || dout_ready`. The output register and `widx` advance only on `ld`.
- `dout_valid` is set by any load and cleared when it is accepted with no new load.
- `rd_stb` = `ld && state==PAYLOAD && rdy && !ts`. It is combinational from registered state, `rdy` and `ts`; there is never more than one strobe per accepted word.
- Latency, `rdy` rising (IDLE, `dout_ready`=1) to first `dout_valid`: 1 cycle.
- Full record with `dout_ready` held high: 32 consecutive valid cycles. `busy` falls the cycle after w31 is loaded.
- Back-to-back messages: minimum 1 IDLE cycle between records.
- Backpressure: with `dout_ready` low, `dout`, `dout_valid`, `widx` and state hold, and `rd_stb` stays 0.
- Reset values (`rst_n` low, async): state IDLE, `widx` 0, `dout` 16'h0, `dout_valid` 0, `rd_stb` 0, `busy` 0, `ovr` 0, `ts_valid` 0.
- Reset or `en` low mid-record: the record is dropped without padding. Downstream must treat `busy` falling before w31 as a discard.

## Test plan
- Nominal:
  - Stimulus: `ts` with sec=32'h12345678, usec=20'hABCDE; source words 0x0100..0x011B; then `rdy`; `dout_ready`=1.
  - Response: w0..w3 = 0xBCDE, {CHANNEL,0,7'h0,4'hA}, 0x5678, 0x1234; then 0x0100..0x011B; exactly 28 `rd_stb`; `ovr`=0.
- Missing timestamp:
  - Stimulus: `rdy` with no prior `ts`.
  - Response: w1 bit 11 (`nots`) = 1; record is still 32 words.
- Backpressure:
  - Stimulus: `dout_ready` toggling with a 1/3 duty cycle.
  - Response: payload sequence intact, no duplicate or skipped words, `rd_stb` count = 28.
- Abort on `ts`:
  - Stimulus: `ts` during payload word 10.
  - Response: words 10..27 are 0x0000, `ovr`=1, strobes stop at 10, new timestamp appears in the next record's header.
- `rdy` drop:
  - Stimulus: source `rdy` falls after 5 strobes.
  - Response: 23 padding zeros, `ovr`=1, `busy` falls after w31.
- Reset mid-record:
  - Stimulus: `rst_n` low asynchronously at payload word 3.
  - Response: all outputs go to reset values immediately; the next `rdy` starts a clean record with `nots`=1.
